// File: rtl/farrow_fir_bank.sv
// farrow_fir_bank: multichannel TDM Farrow sub-filter bank, polinom parallel N_tap-tap FIRs per input sample
//   clk, rst                  clock, synchronous active-high reset
//   vld_in, last_in, data_in  input sample stream; last_in marks the final channel of a frame
//   rdy_in                    high only while idle; samples and coefficient writes land only then
//   coef_we, coef_branch,
//   coef_tap, coef_data       coefficient write port
//   data_out[b]               branch b result, weighted by d^b in the downstream Horner chain
//   vld_out, last_out         one-cycle output strobe and the producing sample's last_in
module farrow_fir_bank #(
    parameter int width_data = 21,
    parameter int width_coef = 18,
    parameter int polinom    = 5,
    parameter int N_tap      = 8,
    parameter int N_chanel   = 32,
    parameter int shift_fir  = 17,
    parameter int round_fir  = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vld_in,
    input  logic                       last_in,
    input  logic [width_data-1:0]      data_in,
    output logic                       rdy_in,
    input  logic                       coef_we,
    input  logic [$clog2(polinom)-1:0] coef_branch,
    input  logic [$clog2(N_tap)-1:0]   coef_tap,
    input  logic [width_coef-1:0]      coef_data,
    output logic [width_data-1:0]      data_out [polinom-1:0],
    output logic                       vld_out,
    output logic                       last_out
);
    localparam int tw = $clog2(N_tap);
    localparam int cw = $clog2(N_chanel);
    localparam int mw = $clog2(N_tap + 1);
    localparam int aw = width_data + width_coef + tw;
    localparam int hw = cw + tw;
    localparam logic [hw-1:0] clr_last = hw'(N_chanel * N_tap - 1);
    localparam logic [mw-1:0] mac_last = mw'(N_tap);
    localparam logic [cw-1:0] ch_last = cw'(N_chanel - 1);
    localparam logic signed [aw-1:0] rnd_c = aw'(round_fir);
    localparam logic signed [aw-1:0] max_c = {{(aw - width_data + 1){1'b0}}, {(width_data - 1){1'b1}}};
    localparam logic signed [aw-1:0] min_c = ~max_c;
    typedef enum logic [2:0] {CLEAR, IDLE, WRITE, MAC, ROUND, OUT} state_t;
    state_t state, state_nx;
    logic [hw-1:0] clr_cnt;
    logic [mw-1:0] mac_cnt;
    logic [cw-1:0] ch_cnt;
    logic [tw-1:0] wr_ptr [N_chanel];
    logic signed [width_coef-1:0] coef [polinom][N_tap];
    logic signed [width_data-1:0] hist [N_chanel * N_tap];
    logic signed [width_data-1:0] smp, q;
    logic lst;
    logic signed [aw-1:0] acc [polinom];
    logic signed [aw-1:0] shf [polinom];
    logic [width_data-1:0] sat [polinom-1:0];
    logic [width_data-1:0] rnd [polinom-1:0];
    logic accept, cwe;
    logic [tw-1:0] tap_rd;
    logic [hw-1:0] wr_addr, rd_addr;
    // The cycle after OUT (vld_out high) is still busy, which sets the N_tap+6 sample spacing.
    always_comb begin
        state_nx = state;
        rdy_in = 1'b0;
        case (state)
            CLEAR: state_nx = clr_cnt == clr_last ? IDLE : CLEAR;
            IDLE: begin
                rdy_in = !vld_out;
                state_nx = vld_in && !vld_out ? WRITE : IDLE;
            end
            WRITE: state_nx = MAC;
            MAC: state_nx = mac_cnt == mac_last ? ROUND : MAC;
            ROUND: state_nx = OUT;
            OUT: state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end
    assign accept = vld_in && rdy_in;
    assign cwe = coef_we && rdy_in && int'(coef_branch) < polinom;
    // RAM data arriving at mac_cnt=c was addressed at c-1, so the coefficient lags by one tap.
    assign tap_rd = mac_cnt[tw-1:0] - 1'b1;
    assign wr_addr = {ch_cnt, wr_ptr[ch_cnt]};
    assign rd_addr = {ch_cnt, wr_ptr[ch_cnt] - mac_cnt[tw-1:0]};
    always_comb begin
        for (int b = 0; b < polinom; b++) begin
            shf[b] = (acc[b] + rnd_c) >>> shift_fir;
            sat[b] = shf[b] > max_c ? max_c[width_data-1:0] : shf[b] < min_c ? min_c[width_data-1:0] : shf[b][width_data-1:0];
        end
    end
    always_ff @(posedge clk) begin
        q <= hist[rd_addr];
        if (state == CLEAR) hist[clr_cnt] <= '0;
        else if (state == WRITE) hist[wr_addr] <= smp;
        if (accept) begin
            smp <= data_in;
            lst <= last_in;
        end
        if (state == ROUND) rnd <= sat;
        for (int b = 0; b < polinom; b++) begin
            if (state == WRITE) acc[b] <= '0;
            else if (state == MAC && mac_cnt != '0) acc[b] <= acc[b] + aw'(q) * aw'(coef[b][tap_rd]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            clr_cnt <= '0;
            mac_cnt <= '0;
            ch_cnt <= '0;
            vld_out <= 1'b0;
            last_out <= 1'b0;
            for (int c = 0; c < N_chanel; c++) wr_ptr[c] <= '0;
            for (int b = 0; b < polinom; b++) begin
                data_out[b] <= '0;
                for (int k = 0; k < N_tap; k++) coef[b][k] <= '0;
            end
        end else begin
            state <= state_nx;
            clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
            mac_cnt <= state == MAC ? mac_cnt + 1'b1 : '0;
            vld_out <= state == OUT;
            if (cwe) coef[coef_branch][coef_tap] <= coef_data;
            if (state == OUT) begin
                data_out <= rnd;
                last_out <= lst;
                wr_ptr[ch_cnt] <= wr_ptr[ch_cnt] + 1'b1;
                ch_cnt <= lst || ch_cnt == ch_last ? '0 : ch_cnt + 1'b1;
            end
        end
    end
endmodule
